gmii_tx_fifo18: RTL and testbench
=================================

GMII_TX_FIFO18 -- requirements
Module: gmii_tx_fifo18

Interface
REQ-001 SHALL have parameter Gap, default 4'hC, inter-frame gap in gmii_tx_clk cycles (legal 4'h4..4'hF).
REQ-002 SHALL have parameter MinLen, default 11'd60, minimum frame length in bytes before FCS.
REQ-003 SHALL have port gmii_tx_clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port dout, input, 18, FIFO word: [17] end-of-frame, [16] odd (only [15:8] valid; legal only with [17]), [15:8] first byte, [7:0] second byte.
REQ-006 SHALL have port empty, input, 1, FIFO empty.
REQ-007 SHALL have port rd_en, output, 1, FIFO read strobe; word valid on dout the cycle after rd_en (non-FWFT).
REQ-008 SHALL have port frame_ready, input, 1, level: at least one complete frame is queued.
REQ-009 SHALL have port gmii_txd, output, 8, GMII transmit data, registered.
REQ-010 SHALL have port gmii_tx_en, output, 1, GMII transmit enable, registered.
REQ-011 SHALL have port gmii_tx_er, output, 1, GMII transmit error, registered.
REQ-012 SHALL have port tx_frame_cnt, output, 32, frames completed with good FCS.
REQ-013 SHALL have port tx_underrun_cnt, output, 16, frames aborted on underrun.

Function
REQ-014 SHALL implement states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, ABORT.
REQ-015 IDLE -> PREAMBLE SHALL occur when frame_ready=1 and empty=0; gmii_tx_en rises the following cycle.
REQ-016 PREAMBLE SHALL emit 8'h55 for 7 cycles; SFD SHALL emit 8'hD5 for 1 cycle.
REQ-017 rd_en SHALL pulse in the last PREAMBLE cycle, so the first word is latched during SFD.
REQ-018 DATA SHALL emit [15:8] then [7:0] of each word, one byte per cycle with no bubbles; the next rd_en SHALL be issued during the first-byte cycle of the current word unless it has [17]=1.
REQ-019 A word with [17]=1 and [16]=1 SHALL emit only [15:8].
REQ-020 After the last data byte: if the byte count is below MinLen, go to PAD and emit 8'h00 until the count equals MinLen; otherwise go to FCS.
REQ-021 FCS SHALL emit 4 bytes of IEEE 802.3 CRC-32, least-significant byte first. Polynomial 0x04C11DB7 reflected, init 32'hFFFFFFFF, output complemented. Coverage is data plus pad only.
REQ-022 IFG SHALL hold gmii_tx_en=0 for exactly Gap cycles, then return to IDLE.
REQ-023 tx_frame_cnt SHALL increment by 1 on the last FCS cycle, wrapping at 2^32.
REQ-024 The byte counter SHALL be 11 bits and saturate at 2047; frames longer than that are still sent in full.
REQ-025 Underrun: if a DATA-state read is due while empty=1, the block SHALL:
- in that cycle drive gmii_tx_er=1 with gmii_tx_en=1;
- in the next cycle drop gmii_tx_en;
- increment tx_underrun_cnt (saturating at 16'hFFFF);
- enter ABORT.
REQ-026 ABORT SHALL read and discard words whenever empty=0 until a word with [17]=1 is consumed, then go to IFG; gmii_tx_en=0 and gmii_tx_er=0 throughout.
REQ-027 frame_ready SHALL be sampled only in IDLE; deassertion mid-frame has no effect.
REQ-028 rd_en SHALL never be asserted while empty=1.
REQ-029 gmii_txd SHALL be 8'h00 whenever gmii_tx_en=0.

Reset
REQ-030 While sys_rst=1 the block SHALL go to IDLE with rd_en=0, gmii_txd=8'h00, gmii_tx_en=0, gmii_tx_er=0, tx_frame_cnt=0, tx_underrun_cnt=0, CRC=32'hFFFFFFFF.
REQ-031 Reset asserted mid-frame SHALL drop gmii_tx_en the cycle after it is sampled. No residual FIFO words are drained; flushing the FIFO is the owner's job via its shared sys_rst.

Verification
REQ-032 60-byte frame (30 words, even) -> 72 consecutive gmii_tx_en cycles: 7x55, D5, 60 data bytes, 4 FCS bytes. The CRC-32 run over data+FCS SHALL give residue 32'hC704DD7B. tx_frame_cnt=1.
REQ-033 14-byte frame -> 14 data bytes, 46 bytes of 00, FCS; 72 gmii_tx_en cycles in total.
REQ-034 61-byte frame (last word [17:16]=2'b11) -> 61 data bytes, no pad, 73 gmii_tx_en cycles in total.
REQ-035 Two 64-byte frames queued back to back -> gmii_tx_en low for exactly 12 cycles between them; tx_frame_cnt=2.
REQ-036 empty forced high after word 5 of a 100-byte frame:
- gmii_tx_er=1 for exactly 1 cycle;
- tx_underrun_cnt=1;
- the remaining words are drained through EOF;
- the next frame then transmits correctly.
REQ-037 sys_rst pulsed during byte 20 of DATA -> all outputs at reset values the next cycle; the next frame starts with a full preamble.

Source files
------------

// File: rtl/gmii_tx_fifo18.sv
// GMII transmitter fed by an 18-bit non-FWFT frame FIFO: adds preamble/SFD,
// pads short frames, appends the Ethernet FCS and enforces the inter-frame gap.
module gmii_tx_fifo18 #(
  parameter logic [3:0]  Gap    = 4'hC,
  parameter logic [10:0] MinLen = 11'd60
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic [17:0] dout,
  input  logic        empty,
  output logic        rd_en,
  input  logic        frame_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [31:0] tx_frame_cnt,
  output logic [15:0] tx_underrun_cnt
);

  localparam int unsigned WordW = 18;
  localparam int unsigned CntW  = 4;
  localparam int unsigned LenW  = 11;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_ABORT
  } state_t;

  state_t            r_state, w_state;
  logic [CntW-1:0]   r_cnt, w_cnt;
  logic              r_phase, w_phase;
  logic [WordW-1:0]  r_word, w_word;
  logic [LenW-1:0]   r_len, w_len, w_len_inc;
  logic [31:0]       r_crc, w_crc, w_fcs;
  logic              r_rd_pend, w_rd_pend;
  logic              w_rd, w_tx_en, w_tx_er, w_frame_inc, w_urun_inc, w_last;
  logic [7:0]        w_txd, w_byte;

  // Reflected CRC-32 (0xEDB88320), LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign w_len_inc = (r_len == 11'h7FF) ? r_len : LenW'(r_len + 11'd1);
  assign w_fcs     = ~(r_crc >> {r_cnt[1:0], 3'b000});
  assign w_byte    = r_phase ? r_word[7:0] : r_word[15:8];
  assign rd_en     = w_rd & ~sys_rst;

  always_comb begin : next_state
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_phase     = r_phase;
    w_word      = r_word;
    w_len       = r_len;
    w_crc       = r_crc;
    w_rd_pend   = 1'b0;
    w_rd        = 1'b0;
    w_txd       = 8'h00;
    w_tx_en     = 1'b0;
    w_tx_er     = 1'b0;
    w_frame_inc = 1'b0;
    w_urun_inc  = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt   = '0;
        w_len   = '0;
        w_crc   = '1;
        w_phase = 1'b0;
        if (frame_ready && !empty) w_state = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        w_tx_en = 1'b1;
        w_txd   = 8'h55;
        if (r_cnt == 4'd6) begin
          w_rd    = ~empty;
          w_cnt   = '0;
          w_state = S_SFD;
        end else begin
          w_cnt = CntW'(r_cnt + 4'd1);
        end
      end
      S_SFD: begin
        w_tx_en = 1'b1;
        w_txd   = 8'hD5;
        w_word  = dout;
        w_phase = 1'b0;
        w_state = S_DATA;
      end
      S_DATA: begin
        // Next word is requested on the high byte so it lands in time for the low byte.
        w_tx_en = 1'b1;
        w_txd   = w_byte;
        w_crc   = crc_byte(r_crc, w_byte);
        w_len   = w_len_inc;
        if (!r_phase) begin
          if (r_word[17] && r_word[16]) begin
            w_last = 1'b1;
          end else begin
            w_phase = 1'b1;
            if (!r_word[17]) begin
              if (empty) begin
                w_tx_er    = 1'b1;
                w_urun_inc = 1'b1;
                w_state    = S_ABORT;
              end else begin
                w_rd = 1'b1;
              end
            end
          end
        end else if (r_word[17]) begin
          w_last = 1'b1;
        end else begin
          w_word  = dout;
          w_phase = 1'b0;
        end
        if (w_last) begin
          w_cnt   = '0;
          w_state = (w_len_inc < MinLen) ? S_PAD : S_FCS;
        end
      end
      S_PAD: begin
        w_tx_en = 1'b1;
        w_crc   = crc_byte(r_crc, 8'h00);
        w_len   = w_len_inc;
        if (w_len_inc >= MinLen) begin
          w_cnt   = '0;
          w_state = S_FCS;
        end
      end
      S_FCS: begin
        w_tx_en = 1'b1;
        w_txd   = w_fcs[7:0];
        if (r_cnt == 4'd3) begin
          w_frame_inc = 1'b1;
          w_cnt       = '0;
          w_state     = S_IFG;
        end else begin
          w_cnt = CntW'(r_cnt + 4'd1);
        end
      end
      S_IFG: begin
        // The IDLE decision cycle is the last idle cycle of the gap.
        if (r_cnt == CntW'(Gap - 4'd2)) begin
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_cnt = CntW'(r_cnt + 4'd1);
        end
      end
      S_ABORT: begin
        if (r_rd_pend && dout[17]) begin
          w_cnt   = '0;
          w_state = S_IFG;
        end else if (!empty) begin
          w_rd      = 1'b1;
          w_rd_pend = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_phase         <= 1'b0;
      r_word          <= '0;
      r_len           <= '0;
      r_crc           <= '1;
      r_rd_pend       <= 1'b0;
      gmii_txd        <= 8'h00;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      tx_frame_cnt    <= '0;
      tx_underrun_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_phase    <= w_phase;
      r_word     <= w_word;
      r_len      <= w_len;
      r_crc      <= w_crc;
      r_rd_pend  <= w_rd_pend;
      gmii_txd   <= w_txd;
      gmii_tx_en <= w_tx_en;
      gmii_tx_er <= w_tx_er;
      if (w_frame_inc) tx_frame_cnt <= 32'(tx_frame_cnt + 32'd1);
      if (w_urun_inc && tx_underrun_cnt != 16'hFFFF)
        tx_underrun_cnt <= 16'(tx_underrun_cnt + 16'd1);
    end
  end

endmodule

// File: tb/tb_gmii_tx_fifo18.sv
// Bench for gmii_tx_fifo18: a queue-backed FIFO model feeds random frames and the
// GMII byte stream is compared with an expected frame built from data, pad and CRC.
module tb_gmii_tx_fifo18;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [17:0] dout = '0;
  logic        empty, rd_en, frame_ready;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en, gmii_tx_er;
  logic [31:0] tx_frame_cnt;
  logic [15:0] tx_underrun_cnt;

  gmii_tx_fifo18 dut (
    .gmii_tx_clk     (clk),
    .sys_rst         (sys_rst),
    .dout            (dout),
    .empty           (empty),
    .rd_en           (rd_en),
    .frame_ready     (frame_ready),
    .gmii_txd        (gmii_txd),
    .gmii_tx_en      (gmii_tx_en),
    .gmii_tx_er      (gmii_tx_er),
    .tx_frame_cnt    (tx_frame_cnt),
    .tx_underrun_cnt (tx_underrun_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: non-FWFT, flushed by the shared reset
  logic [17:0] mem [0:4095];
  int wp = 0, rp = 0, eof_w = 0, eof_r = 0;
  bit force_empty = 1'b0;

  assign empty       = (wp == rp) || force_empty;
  assign frame_ready = (eof_w != eof_r);

  always @(posedge clk) begin
    if (sys_rst) begin
      rp    <= wp;
      eof_r <= eof_w;
    end else if (rd_en) begin
      dout <= mem[rp & 4095];
      rp   <= rp + 1;
      if (mem[rp & 4095][17]) eof_r <= eof_r + 1;
    end
  end

  int viol_txd = 0, viol_rd = 0;
  always @(negedge clk) begin
    if (gmii_tx_en === 1'b0 && gmii_txd !== 8'h00) viol_txd++;
    if (rd_en === 1'b1 && empty) viol_rd++;
  end

  int checks = 0, errors = 0;
  int exp_frames = 0, exp_urun = 0;
  localparam int MIN_LEN = 60;

  logic [31:0] crc_tab [0:255];
  logic [7:0]  tx_data[$], exp_q[$], exp_a[$], cap_q[$];
  int cap_er, cap_er_idx, cap_gap;
  bit cap_ok;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    return crc_tab[c[7:0] ^ b] ^ (c >> 8);
  endfunction

  function automatic void build_table();
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
  endfunction

  // Expected wire image: preamble, SFD, data, zero pad to MIN_LEN, inverted CRC LSB first
  function automatic void build_expected();
    logic [31:0] c;
    int n;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    foreach (tx_data[i]) begin
      exp_q.push_back(tx_data[i]);
      c = crc_upd(c, tx_data[i]);
    end
    n = tx_data.size();
    while (n < MIN_LEN) begin
      exp_q.push_back(8'h00);
      c = crc_upd(c, 8'h00);
      n++;
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8 * i)));
  endfunction

  function automatic logic [31:0] residue();
    logic [31:0] c, r;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < cap_q.size(); i++) c = crc_upd(c, cap_q[i]);
    r = {<<{c}};
    return r;
  endfunction

  task automatic gen_data(input int len);
    tx_data.delete();
    for (int i = 0; i < len; i++) tx_data.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic push_frame();
    for (int i = 0; i < tx_data.size(); i += 2) begin
      logic last, odd;
      logic [7:0] lo;
      last = (i + 2 >= tx_data.size());
      odd  = (i + 1 == tx_data.size());
      lo   = odd ? 8'h00 : tx_data[i+1];
      mem[wp & 4095] = {last, odd, tx_data[i], lo};
      wp++;
    end
    eof_w++;
  endtask

  task automatic capture_burst(input int budget);
    cap_q.delete();
    cap_er = 0; cap_er_idx = -1; cap_gap = 0; cap_ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (gmii_tx_en) break;
      cap_gap++;
    end
    if (gmii_tx_en !== 1'b1) return;
    for (int n = 0; n < budget; n++) begin
      if (!gmii_tx_en) begin
        cap_ok = 1'b1;
        break;
      end
      cap_q.push_back(gmii_txd);
      if (gmii_tx_er) begin
        cap_er++;
        cap_er_idx = cap_q.size() - 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (gmii_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b expected 0", gmii_tx_en); end
    checks++; if (gmii_txd !== 8'h00) begin errors++; $display("FAIL reset_txd: got %h expected 00", gmii_txd); end
    checks++; if (gmii_tx_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er: got %b expected 0", gmii_tx_er); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    checks++; if (tx_frame_cnt !== 32'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", tx_frame_cnt); end
    checks++; if (tx_underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_urun_cnt: got %0d expected 0", tx_underrun_cnt); end
    sys_rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (gmii_tx_en !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL idle_no_frame: got en=%b rd=%b expected 0 0", gmii_tx_en, rd_en); end
  endtask

  task automatic test_frame(input int len, input string name);
    int bad, first;
    logic [7:0] got;
    gen_data(len);
    build_expected();
    @(negedge clk);
    push_frame();
    capture_burst(len + 300);
    exp_frames++;
    checks++; if (!cap_ok) begin errors++; $display("FAIL %s_timeout: got no complete burst expected %0d bytes", name, exp_q.size()); end
    checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_len: got %0d en cycles expected %0d", name, cap_q.size(), exp_q.size()); end
    bad = 0; first = -1;
    foreach (exp_q[i]) if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    got = (first >= 0 && first < cap_q.size()) ? cap_q[first] : 8'h00;
    checks++; if (bad != 0) begin errors++; $display("FAIL %s_bytes: %0d wrong, first at %0d got %h expected %h", name, bad, first, got, exp_q[first]); end
    checks++; if (cap_er != 0) begin errors++; $display("FAIL %s_tx_er: got %0d er cycles expected 0", name, cap_er); end
    checks++; if (residue() !== 32'hC704DD7B) begin errors++; $display("FAIL %s_residue: got %h expected c704dd7b", name, residue()); end
    checks++; if (tx_frame_cnt !== 32'(exp_frames)) begin errors++; $display("FAIL %s_frame_cnt: got %0d expected %0d", name, tx_frame_cnt, exp_frames); end
    checks++; if (tx_underrun_cnt !== 16'(exp_urun)) begin errors++; $display("FAIL %s_urun_cnt: got %0d expected %0d", name, tx_underrun_cnt, exp_urun); end
  endtask

  task automatic test_back_to_back();
    int bad_a, bad_b, gap;
    gen_data(64); build_expected(); exp_a = exp_q;
    @(negedge clk);
    push_frame();
    gen_data(64); build_expected();
    push_frame();
    capture_burst(400);
    bad_a = (cap_q.size() == exp_a.size()) ? 0 : 1;
    foreach (exp_a[i]) if (i < cap_q.size() && cap_q[i] !== exp_a[i]) bad_a++;
    capture_burst(400);
    gap = cap_gap + 1;
    bad_b = (cap_q.size() == exp_q.size()) ? 0 : 1;
    foreach (exp_q[i]) if (i < cap_q.size() && cap_q[i] !== exp_q[i]) bad_b++;
    exp_frames += 2;
    checks++; if (bad_a != 0) begin errors++; $display("FAIL b2b_frame1: got %0d bad bytes expected 0", bad_a); end
    checks++; if (!cap_ok || bad_b != 0) begin errors++; $display("FAIL b2b_frame2: got %0d bad bytes ok=%b expected 0 ok=1", bad_b, cap_ok); end
    checks++; if (gap != 12) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles expected 12", gap); end
    checks++; if (tx_frame_cnt !== 32'(exp_frames)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", tx_frame_cnt, exp_frames); end
  endtask

  task automatic test_underrun();
    int start, bad, en_during;
    gen_data(100);
    build_expected();
    @(negedge clk);
    start = wp;
    push_frame();
    fork
      capture_burst(400);
      begin
        for (int n = 0; n < 400; n++) begin
          @(negedge clk);
          if (rp - start >= 5) begin
            force_empty = 1'b1;
            break;
          end
        end
      end
    join
    exp_urun++;
    // Words 0..3 plus the high byte of word 4, the underrun cycle carrying tx_er
    bad = 0;
    for (int i = 0; i < 17; i++) if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) bad++;
    checks++; if (!cap_ok || cap_q.size() != 17) begin errors++; $display("FAIL urun_len: got %0d en cycles expected 17", cap_q.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL urun_bytes: got %0d bad bytes expected 0", bad); end
    checks++; if (cap_er != 1 || cap_er_idx != 16) begin errors++; $display("FAIL urun_tx_er: got %0d er cycles at %0d expected 1 at 16", cap_er, cap_er_idx); end
    checks++; if (tx_underrun_cnt !== 16'(exp_urun)) begin errors++; $display("FAIL urun_cnt: got %0d expected %0d", tx_underrun_cnt, exp_urun); end
    checks++; if (tx_frame_cnt !== 32'(exp_frames)) begin errors++; $display("FAIL urun_frame_cnt: got %0d expected %0d", tx_frame_cnt, exp_frames); end
    repeat (8) @(negedge clk);
    force_empty = 1'b0;
    en_during = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (gmii_tx_en) en_during++;
      if (eof_r == eof_w) break;
    end
    repeat (3) @(negedge clk);
    checks++; if (rp != wp || eof_r != eof_w) begin errors++; $display("FAIL urun_drain: got rp=%0d eof_r=%0d expected rp=%0d eof_r=%0d", rp, eof_r, wp, eof_w); end
    checks++; if (en_during != 0) begin errors++; $display("FAIL urun_abort_quiet: got %0d en cycles expected 0", en_during); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    gen_data(60);
    build_expected();
    @(negedge clk);
    push_frame();
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (gmii_tx_en) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_start: got no tx_en expected frame start"); end
    repeat (27) @(negedge clk);
    checks++; if (gmii_tx_en !== 1'b1 || gmii_txd !== tx_data[19]) begin errors++; $display("FAIL rstmid_byte20: got en=%b %h expected en=1 %h", gmii_tx_en, gmii_txd, tx_data[19]); end
    sys_rst = 1'b1;
    @(negedge clk);
    checks++; if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || gmii_tx_er !== 1'b0 || rd_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got en=%b txd=%h er=%b rd=%b expected 0 00 0 0", gmii_tx_en, gmii_txd, gmii_tx_er, rd_en);
    end
    checks++; if (tx_frame_cnt !== 32'd0 || tx_underrun_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_counters: got %0d/%0d expected 0/0", tx_frame_cnt, tx_underrun_cnt); end
    sys_rst = 1'b0;
    exp_frames = 0;
    exp_urun = 0;
  endtask

  task automatic test_protocol();
    checks++; if (viol_rd != 0) begin errors++; $display("FAIL rd_while_empty: got %0d cycles expected 0", viol_rd); end
    checks++; if (viol_txd != 0) begin errors++; $display("FAIL txd_when_idle: got %0d nonzero cycles expected 0", viol_txd); end
  endtask

  initial begin
    sys_rst = 1'b1;
    build_table();
    test_reset();
    test_frame(60, "len60");
    test_frame(14, "len14");
    test_frame(61, "len61");
    test_frame(1, "len1");
    test_back_to_back();
    test_underrun();
    test_frame(60, "after_underrun");
    test_reset_mid();
    test_frame(60, "after_reset");
    test_frame(2101, "len2101");
    for (int k = 0; k < 6; k++) test_frame(int'($urandom_range(1, 130)), "random");
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
